cont_ld_down: RTL
=================

Name: cont_ld_down

Overview:
- Loadable down-counter/timer; the counting-down counterpart of the team's loadable up-counter, and the consumer of its ripple-carry output.
- Accepts a count-enable tick stream (typically the upstream counter's RC) and counts a loaded value down to zero.
- On expiry it emits a cascade borrow and a registered done pulse.
- Used for irrigation/actuator on-time intervals; supports one-shot and auto-reload (periodic) operation.

Parameters:
- W, 4, counter/load width in bits

Ports:
- Ck  in  1  clock; all state changes on rising edge
- Clr  in  1  synchronous, active-high reset; highest priority
- CE  in  1  count enable / tick (e.g. upstream RC); one decrement per cycle when high
- L  in  1  synchronous load strobe
- I  in  W  load value
- Auto  in  1  1 = auto-reload at expiry, 0 = one-shot
- Q  out  W  current count (registered)
- BO  out  1  borrow/terminal-count out, combinational, for cascading
- Done  out  1  registered one-cycle expiry pulse
- Busy  out  1  high while state = RUN

Behaviour:
- State register: IDLE, RUN, DONE. Reload register R (W bits) holds the last loaded value.
- Reset (Clr=1 at an edge, any state): Q=0, R=0, state=IDLE, Done=0. Clr overrides L and CE in the same cycle.
- Load (Clr=0, L=1, any state): Q<=I, R<=I, Done<=0.
  - Next state is RUN if I!=0.
  - Next state is IDLE if I==0; no Done pulse in that case.
  - L overrides CE in the same cycle: no decrement that cycle.
- RUN, L=0, CE=1:
  - Q>1: Q<=Q-1.
  - Q==1, Auto=0: Q<=0, state<=DONE, Done<=1.
  - Q==1, Auto=1: Q<=R, stay in RUN, Done<=1.
- RUN, CE=0: Q holds; Done<=0.
- IDLE and DONE: CE ignored; Q holds (0 in DONE); Done<=0. Only L or Clr leaves these states.
- Auto is sampled at the expiry cycle only. Changing Auto mid-count has no other effect.
- Done is high exactly one cycle, in the cycle after the expiry edge, and never in two consecutive cycles unless R==1 with Auto=1 and CE continuous.
- BO = Busy & CE & (Q==1) & ~L & ~Clr.
  - Combinational and asserted in the same cycle as the final decrement, mirroring RC of the up-counter.
  - Downstream stages use BO as their CE.
- Busy = (state==RUN), derived from the state register.
- Latencies:
  - Load to Q: 1 cycle.
  - CE to Q decrement: 1 cycle.
  - Expiry CE to Done: 1 cycle.
- No wrap below zero: Q never transitions 0 -> all-ones.
- Q width is W; arithmetic is unsigned modulo-free because the Q==1 check precedes any decrement.

Test Plan:
- Clr=1 for one cycle after arbitrary state -> Q=0000, Busy=0, Done=0, BO=0.
- L=1, I=0011, Auto=0, then CE=1 for 3 cycles -> Q=0011,0010,0001,0000; BO=1 only in the cycle Q=0001; Done=1 for one cycle with Q=0000; Busy=0 after; further CE leaves Q=0000.
- I=0101 loaded, CE pattern 1,0,0,1 -> Q=0101,0100,0100,0100,0011; Done stays 0.
- Auto=1, I=0010, CE held high 6 cycles -> Q=0010,0001,0010,0001,0010,0001; Done pulses every 2nd cycle; Busy stays 1.
- Mid-run Q=0100:
  - L=1, I=0111 with CE=1 -> Q=0111, no decrement.
  - Next cycle Clr=1 with L=1 -> Q=0000, IDLE.
- L=1 with I=0000 -> Q=0000, Busy=0, no Done pulse; subsequent CE has no effect.

Source files
------------

// File: rtl/cont_ld_down_if.sv
// rtl/cont_ld_down_if.sv - control/status bundle for the loadable down-counter
// master drives tick, load and mode; slave returns count, borrow, done and busy.
interface cont_ld_down_if #(
  parameter int W = 4
);
  logic         CE;
  logic         L;
  logic [W-1:0] I;
  logic         Auto;
  logic [W-1:0] Q;
  logic         BO;
  logic         Done;
  logic         Busy;

  modport master (
    output CE, L, I, Auto,
    input  Q, BO, Done, Busy
  );

  modport slave (
    input  CE, L, I, Auto,
    output Q, BO, Done, Busy
  );
endinterface

// File: rtl/cont_ld_down.sv
// rtl/cont_ld_down.sv - loadable down-counter/timer with borrow cascade and done pulse
// One-shot or auto-reload; BO mirrors the up-counter RC so stages chain CE<-BO.
module cont_ld_down #(
  parameter int W = 4
) (
  input  logic         Ck,
  input  logic         Clr,
  cont_ld_down_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic         done_q, done_d;

  always_ff @(posedge Ck) begin
    if (Clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    if (bus.L) begin
      q_d     = bus.I;
      r_d     = bus.I;
      state_d = (bus.I != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.CE) begin
      // Terminal check comes before any subtraction, so Q can never underflow.
      if (q_q == ONE) begin
        done_d = 1'b1;
        if (bus.Auto) begin
          q_d = r_q;
        end else begin
          q_d     = '0;
          state_d = DONE;
        end
      end else if (q_q != '0) begin
        q_d = q_q - ONE;
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.Done = done_q;
  assign bus.Busy = (state_q == RUN);
  assign bus.BO   = bus.Busy & bus.CE & (q_q == ONE) & ~bus.L & ~Clr;

endmodule
